// File: rtl/mux_scan_demux_if.sv
// Select/return bundle between the scanner and the 4-to-1 mux it walks.
interface mux_scan_demux_if;
    logic       start;
    logic       w;
    logic       s1;
    logic       s0;
    logic [3:0] d_out;
    logic [3:0] err;
    logic       busy;
    logic       done;

    modport master (
        output start, w,
        input  s1, s0, d_out, err, busy, done
    );

    modport slave (
        input  start, w,
        output s1, s0, d_out, err, busy, done
    );
endinterface

// File: rtl/mux_scan_demux.sv
// Walks the mux select through codes 00..11. After each change it waits a
// settle time, then samples the returned line twice and stores the value into
// the matching d_out bit. Channels whose two samples keep disagreeing are
// retried, and once the retries run out they are flagged in err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, select parked at 00
// SETTLE  | select held, counting down the settle time
// CAPTURE | first sample of w taken into smp
// VERIFY  | second sample compared, then store / retry / flag
// DONE    | one-cycle completion pulse, select returns to 00
module mux_scan_demux #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_demux_if.slave bus
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    // With MAX_RETRY = 0 the counter is never incremented, but it still needs one bit.
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, VERIFY, DONE} state_t;

    state_t        state, state_n;
    logic [1:0]    ch, ch_n;
    logic [1:0]    sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retry, retry_n;
    logic          smp, smp_n;
    logic [3:0]    d_out, d_out_n;
    logic [3:0]    err, err_n;
    logic          advance;

    // State and datapath registers; async reset discards any partial scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            sel   <= '0;
            cnt   <= '0;
            retry <= '0;
            smp   <= 1'b0;
            d_out <= '0;
            err   <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            retry <= retry_n;
            smp   <= smp_n;
            d_out <= d_out_n;
            err   <= err_n;
        end
    end

    // Next-state and datapath updates for the scan sequence.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        sel_n   = sel;
        cnt_n   = cnt;
        retry_n = retry;
        smp_n   = smp;
        d_out_n = d_out;
        err_n   = err;
        advance = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    ch_n    = '0;
                    sel_n   = '0;
                    cnt_n   = CNT_LOAD;
                    retry_n = '0;
                    err_n   = '0;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_n = CAPTURE;
                else           cnt_n   = cnt - 1'b1;
            end
            CAPTURE: begin
                smp_n   = bus.w;
                state_n = VERIFY;
            end
            VERIFY: begin
                // An unknown on either sample compares false and is handled as a mismatch.
                if (bus.w == smp) begin
                    d_out_n[ch] = smp;
                    advance     = 1'b1;
                end else if (retry != RETRY_LIM) begin
                    retry_n = retry + 1'b1;
                    cnt_n   = CNT_LOAD;
                    state_n = SETTLE;
                end else begin
                    d_out_n[ch] = bus.w;
                    err_n[ch]   = 1'b1;
                    advance     = 1'b1;
                end
                if (advance) begin
                    if (ch == 2'd3) begin
                        state_n = DONE;
                    end else begin
                        ch_n    = ch + 2'd1;
                        sel_n   = ch + 2'd1;
                        retry_n = '0;
                        cnt_n   = CNT_LOAD;
                        state_n = SETTLE;
                    end
                end
            end
            DONE: begin
                sel_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.s1    = sel[1];
    assign bus.s0    = sel[0];
    assign bus.d_out = d_out;
    assign bus.err   = err;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_mux_scan_demux.sv
// Directed bench for mux_scan_demux: a delayed 4-to-1 mux model drives w,
// optionally disturbed by an injected toggle. Instance 0 uses the default
// parameters, and instance 1 uses SETTLE_CYCLES=1 with MAX_RETRY=0.
module tb_mux_scan_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic inj = 1'b0;
    bit   which = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;

    // Mux inputs: a=1, b=0, c=1, d=1, so bit n of chan is channel n.
    logic [3:0] chan = 4'b1101;
    logic       mux_w0 = 1'b1;
    logic       mux_w1 = 1'b1;

    mux_scan_demux_if if0 ();
    mux_scan_demux_if if1 ();

    mux_scan_demux dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mux_scan_demux #(.SETTLE_CYCLES(1), .MAX_RETRY(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    // Select-to-output delay of 15 ns in the mux model.
    always begin
        @(if0.s1 or if0.s0);
        #15;
        mux_w0 = chan[{if0.s1, if0.s0}];
    end

    always begin
        @(if1.s1 or if1.s0);
        #15;
        mux_w1 = chan[{if1.s1, if1.s0}];
    end

    assign if0.w     = mux_w0 ^ inj;
    assign if1.w     = mux_w1 ^ inj;
    assign if0.start = start & ~which;
    assign if1.start = start & which;

    logic       o_done, o_busy;
    logic [1:0] o_sel;
    logic [3:0] o_dout, o_err;
    assign o_done = which ? if1.done  : if0.done;
    assign o_busy = which ? if1.busy  : if0.busy;
    assign o_sel  = which ? {if1.s1, if1.s0} : {if0.s1, if0.s0};
    assign o_dout = which ? if1.d_out : if0.d_out;
    assign o_err  = which ? if1.err   : if0.err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a scan and watch a fixed number of edges after E0 (step n = #1 after edge n).
    // mode 0 clean, 1 glitch ch2 once, 2 toggle while sel=01, 3 re-pulse start, 4 toggle always
    task automatic run_scan(input bit dut, input int mode, input int budget,
                            output int done_at, output int done_n,
                            output logic busy0, output logic busy_after,
                            output logic [9:0] hist);
        logic [1:0] last;
        which      = dut;
        done_at    = -1;
        done_n     = 0;
        busy_after = 1'bx;
        hist       = '0;
        last       = 2'b00;
        inj        = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = o_busy;
        for (int n = 0; n < budget; n++) begin
            if (o_sel != last) begin
                hist = {hist[7:0], o_sel};
                last = o_sel;
            end
            if (o_done) begin
                done_n++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && n == done_at + 1) busy_after = o_busy;
            case (mode)
                1: begin
                    if (n == 17) inj = 1'b1;
                    if (n == 18) inj = 1'b0;
                end
                2: if (o_sel == 2'b01) inj = ~inj;
                3: begin
                    if (n == 4 || n == 19) start = 1'b1;
                    if (n == 5 || n == 20) start = 1'b0;
                end
                4: inj = ~inj;
                default: ;
            endcase
            @(posedge clk); #1;
        end
        inj   = 1'b0;
        start = 1'b0;
    endtask

    int         d_at, d_n;
    logic       b0, b_after;
    logic [9:0] hist;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(o_dout), 32'(4'b0000));
        chk("rst_err",  32'(o_err),  32'(4'b0000));
        chk("rst_sel",  32'(o_sel),  32'(2'b00));
        chk("rst_busy", 32'(o_busy), 32'(1'b0));
        chk("rst_done", 32'(o_done), 32'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean scan.
        run_scan(1'b0, 0, 45, d_at, d_n, b0, b_after, hist);
        chk("clean_busy0",  32'(b0),      32'(1'b1));
        chk("clean_done_at", 32'(d_at),   32'(24));
        chk("clean_done_n", 32'(d_n),     32'(1));
        chk("clean_busy_after", 32'(b_after), 32'(1'b0));
        chk("clean_sel_seq", 32'(hist),   32'(10'b00_01_10_11_00));
        chk("clean_dout",   32'(o_dout),  32'(4'b1101));
        chk("clean_err",    32'(o_err),   32'(4'b0000));

        // Single glitch on channel 2 between CAPTURE and VERIFY.
        run_scan(1'b0, 1, 45, d_at, d_n, b0, b_after, hist);
        chk("glitch_done_at", 32'(d_at),  32'(30));
        chk("glitch_dout",  32'(o_dout),  32'(4'b1101));
        chk("glitch_err",   32'(o_err),   32'(4'b0000));

        // Channel 1 never settles: two retries, then it is flagged with the last sample (0).
        run_scan(1'b0, 2, 45, d_at, d_n, b0, b_after, hist);
        chk("toggle_done_at", 32'(d_at),  32'(36));
        chk("toggle_err",   32'(o_err),   32'(4'b0010));
        chk("toggle_dout",  32'(o_dout),  32'(4'b1101));

        // start re-pulsed mid-scan is ignored, and err is cleared by the new scan.
        run_scan(1'b0, 3, 45, d_at, d_n, b0, b_after, hist);
        chk("restart_done_at", 32'(d_at), 32'(24));
        chk("restart_done_n", 32'(d_n),   32'(1));
        chk("restart_err",  32'(o_err),   32'(4'b0000));
        chk("restart_dout", 32'(o_dout),  32'(4'b1101));

        // Async reset at edge 10 of a scan.
        which = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_sel", 32'(o_sel), 32'(2'b01));
        rst = 1'b1;
        #1;
        chk("arst_dout", 32'(o_dout), 32'(4'b0000));
        chk("arst_err",  32'(o_err),  32'(4'b0000));
        chk("arst_sel",  32'(o_sel),  32'(2'b00));
        chk("arst_busy", 32'(o_busy), 32'(1'b0));
        #2;
        rst = 1'b0;
        d_n = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) d_n++;
        end
        chk("arst_no_done", 32'(d_n), 32'(0));
        run_scan(1'b0, 0, 45, d_at, d_n, b0, b_after, hist);
        chk("arst_rescan_done_at", 32'(d_at), 32'(24));
        chk("arst_rescan_dout", 32'(o_dout), 32'(4'b1101));

        // SETTLE_CYCLES=1, MAX_RETRY=0, and w toggling on every channel.
        run_scan(1'b1, 4, 20, d_at, d_n, b0, b_after, hist);
        chk("fast_done_at", 32'(d_at), 32'(12));
        chk("fast_err",     32'(o_err), 32'(4'b1111));
        chk("fast_sel_seq", 32'(hist),  32'(10'b00_01_10_11_00));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
